sram_controller: RTL
====================

# sram_controller

Pipeline-facing controller for the off-chip 16-bit SRAM. Serves one 32-bit word load or store from the MEM stage as two 16-bit SRAM accesses. Holds the pipeline by driving `freez` high until the access completes. Its `freez` output feeds the freeze/flush pipeline registers, so this block is the producer of the stall signal those registers consume.

## Interface
Parameters:
- `WAIT_CYCLES`, 2 — clock cycles each 16-bit half-access is held on the SRAM bus; legal range 1..15.
- `BASE_ADDR`, 1024 — byte address of SRAM word 0.

Ports:
- `clock`  in  1  single system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `wr_en`  in  1  store request from the MEM stage.
- `rd_en`  in  1  load request from the MEM stage.
- `address`  in  32  byte address; word-aligned.
- `write_data`  in  32  store data.
- `read_data`  out  32  load result (registered).
- `freez`  out  1  stall to all pipeline registers; 1 = hold.
- `sram_dq`  inout  16  SRAM data bus.
- `sram_addr`  out  18  SRAM half-word address.
- `sram_we_n`  out  1  write strobe, active-low.
- `sram_ce_n`, `sram_oe_n`, `sram_ub_n`, `sram_lb_n`  out  1 each  tied 0.

## Operation
- Word index `idx = (address - BASE_ADDR) >> 2`, 17 bits, upper bits discarded.
- SRAM address per half: `sram_addr = {idx, h}`.
  - `h=0`: low half, bits [15:0].
  - `h=1`: high half, bits [31:16].
- FSM states and transitions:
  - IDLE:
    - `wr_en` → LOW; write wins if both `wr_en` and `rd_en` are asserted.
    - `rd_en` (miss) → LOW.
    - Otherwise stay in IDLE.
    - On a request, latch `idx`, `write_data`, and the op.
  - LOW: held for exactly `WAIT_CYCLES` cycles (4-bit counter), then → HIGH.
  - HIGH: held for exactly `WAIT_CYCLES` cycles, then → DONE.
  - DONE: one cycle, then → IDLE.
- Writes:
  - In LOW/HIGH, `sram_we_n=0` for the whole state.
  - `sram_dq` is driven with the matching latched half.
- Reads:
  - `sram_dq` is high-Z and `sram_we_n=1`.
  - On the last cycle of LOW, `read_data[15:0]` ← `sram_dq`.
  - On the last cycle of HIGH, `read_data[31:16]` ← `sram_dq`.
- Outside write states: `sram_dq` is high-Z, `sram_we_n=1`, and `sram_addr` holds its last value.
- `freez` is combinational:
  - 1 in IDLE when a request is present (excluding a buffered read hit).
  - 1 in LOW and HIGH.
  - 0 in DONE and in idle with no request.
- A store leaves `read_data` unchanged.

## Timing
- Reset values:
  - State IDLE, counter 0.
  - `read_data=0`, `sram_we_n=1`, `sram_dq` high-Z, `sram_addr=0`.
  - `freez` follows its combinational rule.
- Request first seen in IDLE at cycle t:
  - `freez=1` for cycles t .. t+2·`WAIT_CYCLES`.
  - DONE at cycle t+2·`WAIT_CYCLES`+1 with `freez=0` and `read_data` valid.
  - The pipeline advances at the end of DONE.
- Back-to-back requests: after DONE the block spends at least one IDLE cycle; a request present then starts a new access with no extra gap.
- Requests are sampled only in IDLE. `address`, `write_data` and op changes during LOW, HIGH or DONE are ignored.
- Reset asserted mid-access: at the next edge the FSM returns to IDLE, `sram_we_n=1` and `sram_dq` is released. A partial store may leave one half written; no retry.

## Configuration
- `SRAM_READ_BUFFER_EN` defined:
  - Adds a one-entry read buffer: a valid bit plus a 17-bit tag. `read_data` serves as the buffer data.
  - A completed read sets valid and tag = `idx`.
  - Any store, on entering LOW, clears valid.
  - Reset clears valid.
  - In IDLE, `rd_en && !wr_en && valid && tag==idx` is a hit: `freez=0` that cycle, FSM stays in IDLE, no SRAM access.
- Not defined: every read takes the full 2·`WAIT_CYCLES`+1 stall. The buffer logic is absent.

## Test plan
- Reset: hold `reset` 2 cycles → `read_data=0`, `sram_we_n=1`, `sram_dq` high-Z, `freez=0` with no request.
- Store then load, `WAIT_CYCLES=2`:
  - Store 0xDEADBEEF to address 1032 → `sram_addr` 4 then 5, `sram_dq` 0xBEEF then 0xDEAD, `freez` high 5 cycles.
  - Then load 1032 → `read_data=0xDEADBEEF` in DONE.
- Simultaneous `wr_en` and `rd_en` → a store is performed and `read_data` is unchanged.
- Reset on the second cycle of HIGH during a store → `sram_we_n=1` next cycle, FSM in IDLE, `freez=0` when idle.
- `WAIT_CYCLES=1`: load → `freez` high exactly 3 cycles, DONE on the 4th.
- With `SRAM_READ_BUFFER_EN`:
  - Load 1040 twice → the second load has `freez=0` and no `sram_addr` activity.
  - Store to 2000, then load 1040 → full stall.

Source files
------------

// File: rtl/sram_controller.sv
// sram_controller: serves one 32-bit load/store from the MEM stage as two
// 16-bit accesses to an asynchronous off-chip SRAM. The low half is accessed
// first, then the high half, and each half is held for WAIT_CYCLES clocks.
// freez stalls the pipeline until the access reaches DONE.
// Optional feature macro: SRAM_READ_BUFFER_EN adds a one-entry read buffer.
// A repeated load of the most recently read word is then served without
// touching the SRAM.
module sram_controller #(
    parameter int WAIT_CYCLES = 2,
    parameter int BASE_ADDR   = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        freez,
    inout  wire  [15:0] sram_dq,
    output logic [17:0] sram_addr,
    output logic        sram_we_n,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_ub_n,
    output logic        sram_lb_n
);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t      state_reg;
    logic [3:0]  cnt_reg;
    logic [16:0] idx_reg;
    logic [15:0] wdata_hi_reg;
    logic        op_write_reg;
    logic        dq_oe_reg;
    logic [15:0] dq_out_reg;
    logic [31:0] read_data_reg;
    logic [17:0] sram_addr_reg;
    logic        we_n_reg;

    logic [31:0] offset;
    logic [16:0] req_idx;
    logic        last_cycle;
    logic        read_hit;
    logic        start_req;
    logic [14:0] unused_offset_bits;

    // Word index relative to the SRAM window; bits outside the 17-bit index are dropped.
    assign offset             = address - 32'(BASE_ADDR);
    assign req_idx            = offset[18:2];
    assign unused_offset_bits = {offset[31:19], offset[1:0]};

    assign last_cycle = (cnt_reg == 4'(WAIT_CYCLES - 1));

`ifdef SRAM_READ_BUFFER_EN
    logic        buf_valid_reg;
    logic [16:0] buf_tag_reg;

    assign read_hit = rd_en && !wr_en && buf_valid_reg && (buf_tag_reg == req_idx);

    // Read buffer bookkeeping: read_data doubles as the buffered word.
    always_ff @(posedge clock) begin
        if (reset) begin
            buf_valid_reg <= 1'b0;
            buf_tag_reg   <= '0;
        end else if (state_reg == IDLE && wr_en) begin
            buf_valid_reg <= 1'b0;
        end else if (state_reg == HIGH && last_cycle && !op_write_reg) begin
            buf_valid_reg <= 1'b1;
            buf_tag_reg   <= idx_reg;
        end
    end
`else
    assign read_hit = 1'b0;
`endif

    // A store always wins over a simultaneous load.
    assign start_req = wr_en || (rd_en && !read_hit);

    // Stall while a request waits in IDLE and throughout both half-accesses.
    assign freez = ((state_reg == IDLE) && start_req) ||
                   (state_reg == LOW) || (state_reg == HIGH);

    // Access sequencer; SRAM pins are registered so they line up with the state they belong to.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            idx_reg       <= '0;
            wdata_hi_reg  <= '0;
            op_write_reg  <= 1'b0;
            dq_oe_reg     <= 1'b0;
            dq_out_reg    <= '0;
            read_data_reg <= '0;
            sram_addr_reg <= '0;
            we_n_reg      <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start_req) begin
                        idx_reg       <= req_idx;
                        wdata_hi_reg  <= write_data[31:16];
                        op_write_reg  <= wr_en;
                        cnt_reg       <= '0;
                        sram_addr_reg <= {req_idx, 1'b0};
                        we_n_reg      <= !wr_en;
                        dq_oe_reg     <= wr_en;
                        dq_out_reg    <= write_data[15:0];
                        state_reg     <= LOW;
                    end
                end
                LOW: begin
                    if (last_cycle) begin
                        if (!op_write_reg) begin
                            read_data_reg[15:0] <= sram_dq;
                        end
                        cnt_reg       <= '0;
                        sram_addr_reg <= {idx_reg, 1'b1};
                        dq_out_reg    <= wdata_hi_reg;
                        state_reg     <= HIGH;
                    end else begin
                        cnt_reg <= cnt_reg + 4'd1;
                    end
                end
                HIGH: begin
                    if (last_cycle) begin
                        if (!op_write_reg) begin
                            read_data_reg[31:16] <= sram_dq;
                        end
                        cnt_reg   <= '0;
                        we_n_reg  <= 1'b1;
                        dq_oe_reg <= 1'b0;
                        state_reg <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 4'd1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign sram_dq   = dq_oe_reg ? dq_out_reg : 16'hzzzz;
    assign sram_addr = sram_addr_reg;
    assign sram_we_n = we_n_reg;
    assign read_data = read_data_reg;
    assign sram_ce_n = 1'b0;
    assign sram_oe_n = 1'b0;
    assign sram_ub_n = 1'b0;
    assign sram_lb_n = 1'b0;

endmodule
